// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin shared carry-lookahead adder with one-deep result slot
//
// Purpose:
//   NREQ requesters share one WIDTH-bit carry-lookahead adder. At most one
//   operand pair is accepted per cycle, chosen round-robin starting at the
//   requester after the last winner. The WIDTH+1-bit sum is registered into a
//   single output slot tagged with the winner's index and drained by a
//   valid/ready handshake.
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous active-high reset
//   i_req          per-requester request, held with operands until granted
//   i_add1/i_add2  packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_gnt          combinational one-hot grant for the accepting cycle
//   o_result       registered {carry, sum}
//   o_result_id    index of the requester owning o_result
//   o_result_valid output slot full
//   i_result_ready consumer takes o_result when valid && ready
//   o_grant_cnt    wrapping count of accepted requests
module adder_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_add1,
    input  logic [NREQ*WIDTH-1:0] i_add2,
    output logic [NREQ-1:0]       o_gnt,
    output logic [WIDTH:0]        o_result,
    output logic [IDW-1:0]        o_result_id,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic [15:0]           o_grant_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    slot_state_e     state_q, state_d;
    logic [WIDTH:0]  result_q, result_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [15:0]     cnt_q, cnt_d;

    // Arbitration results
    logic            found;
    int              win_idx;
    int              scan_idx;
    logic            accept;

    // Shared adder signals
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] gen, prop;
    logic [WIDTH:0]   carry;
    logic             term;
    logic [WIDTH:0]   sum;

    // Round-robin scan: start at ptr and wrap modulo NREQ; first set request wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = 0;
        scan_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && i_req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // A new result may enter when the slot is empty or being drained this cycle.
    assign accept = found && ((state_q == S_EMPTY) || i_result_ready) && !i_rst;

    always_comb begin
        o_gnt = '0;
        if (accept) begin
            o_gnt[win_idx] = 1'b1;
        end
    end

    assign op_a = i_add1[win_idx*WIDTH +: WIDTH];
    assign op_b = i_add2[win_idx*WIDTH +: WIDTH];

    // Carry-lookahead: every carry is a flat OR of generate terms propagated
    // through the intervening bits, rather than a ripple chain.
    always_comb begin
        gen      = op_a & op_b;
        prop     = op_a ^ op_b;
        carry    = '0;
        term     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & prop[m];
                end
                carry[i+1] = carry[i+1] | term;
            end
        end
        sum = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            state_d  = S_FULL;
            result_d = sum;
            id_d     = IDW'(win_idx);
            ptr_d    = (win_idx == NREQ - 1) ? '0 : IDW'(win_idx + 1);
            cnt_d    = cnt_q + 16'd1;
        end else if ((state_q == S_FULL) && i_result_ready) begin
            state_d  = S_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_EMPTY;
            result_q <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_result       = result_q;
    assign o_result_id    = id_q;
    assign o_result_valid = (state_q == S_FULL);
    assign o_grant_cnt    = cnt_q;

endmodule
